// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-read-port register file: parameter
// legality bounds, address-width helper and the read-source selector.
package regfile_mp_pkg;

   localparam int DEPTH_MIN = 2;
   localparam int DEPTH_MAX = 256;
   localparam int NRD_MIN   = 1;
   localparam int NRD_MAX   = 4;

   // Where a read port takes its next data word from.
   typedef enum logic [1:0] {
      RD_SRC_ZERO   = 2'd0,
      RD_SRC_BYPASS = 2'd1,
      RD_SRC_MEM    = 2'd2
   } rd_src_e;

   // ceil(log2(depth)) with a floor of 1 bit, valid for depth up to 512.
   function automatic int addr_bits(input int depth);
      int bits;
      bits = 1;
      for (int i = 1; i < 9; i++) begin
         if ((1 << i) < depth) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: range check, optional zero register, write-first bypass
// and the registered rdata/rvalid outputs.
module regfile_rdport
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int DEPTH    = 16,
   parameter int ZERO_REG = 0,
   parameter int ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_word,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              rd_err
);

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam bit              HAS_ZERO  = (ZERO_REG != 0);

   logic              in_range;
   rd_src_e           src;
   logic [DATA_W-1:0] rdata_next;
   logic [DATA_W-1:0] rdata_reg;
   logic              rvalid_reg;

   assign in_range = ({1'b0, raddr} < DEPTH_EXT);

   // Pick the data source in priority order: out of range, zero register,
   // same-cycle write (write-first), then the stored entry.
   always_comb begin
      src = RD_SRC_MEM;
      if (!in_range) begin
         src = RD_SRC_ZERO;
      end else if (HAS_ZERO && (raddr == '0)) begin
         src = RD_SRC_ZERO;
      end else if (we && (waddr == raddr)) begin
         src = RD_SRC_BYPASS;
      end
   end

   // Data mux driven by the selected source.
   always_comb begin
      rdata_next = '0;
      case (src)
         RD_SRC_BYPASS: rdata_next = wdata;
         RD_SRC_MEM:    rdata_next = mem_word;
         default:       rdata_next = '0;
      endcase
   end

   // Output registers: data only updates on an enabled read, valid pulses once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
      end else begin
         rvalid_reg <= re;
         if (re) begin
            rdata_reg <= rdata_next;
         end
      end
   end

   assign rdata  = rdata_reg;
   assign rvalid = rvalid_reg;
   assign rd_err = re && !in_range;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD registered read ports, one write
// port, optional hard-wired zero entry and an out-of-range error pulse.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int  DATA_W   = 4,
   parameter int  DEPTH    = 16,
   parameter int  NRD      = 2,
   parameter int  ZERO_REG = 0,
   localparam int ADDR_W   = addr_bits(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rvalid,
   output logic                  addr_err
);

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam bit              HAS_ZERO  = (ZERO_REG != 0);

   // Refuse to elaborate with unsupported geometry.
   generate
      if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX)) begin : g_bad_depth
         $error("regfile_mp: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
      end
      if ((NRD < NRD_MIN) || (NRD > NRD_MAX)) begin : g_bad_nrd
         $error("regfile_mp: NRD=%0d outside %0d..%0d", NRD, NRD_MIN, NRD_MAX);
      end
   endgenerate

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic              wr_in_range;
   logic              wr_commit;
   logic [NRD-1:0]    rd_err;
   logic              addr_err_next;
   logic              addr_err_reg;

   assign wr_in_range = ({1'b0, waddr} < DEPTH_EXT);
   // Writes to the hard-wired zero entry are silently dropped.
   assign wr_commit   = we && wr_in_range && !(HAS_ZERO && (waddr == '0));

   // Storage: cleared on reset, written on a committed write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_commit) begin
         mem_reg[waddr] <= wdata;
      end
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] raddr_i;
      logic [DATA_W-1:0] mem_word;

      assign raddr_i  = raddr[gi*ADDR_W +: ADDR_W];
      // Out-of-range indices are masked to zero inside the port.
      assign mem_word = mem_reg[raddr_i];

      regfile_rdport #(
         .DATA_W  (DATA_W),
         .DEPTH   (DEPTH),
         .ZERO_REG(ZERO_REG),
         .ADDR_W  (ADDR_W)
      ) u_rdport (
         .clk     (clk),
         .rst_n   (rst_n),
         .re      (re[gi]),
         .raddr   (raddr_i),
         .we      (we),
         .waddr   (waddr),
         .wdata   (wdata),
         .mem_word(mem_word),
         .rdata   (rdata[gi*DATA_W +: DATA_W]),
         .rvalid  (rvalid[gi]),
         .rd_err  (rd_err[gi])
      );
   end

   assign addr_err_next = (we && !wr_in_range) || (|rd_err);

   // Error flag pulses for one cycle after any out-of-range enabled access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_reg <= 1'b0;
      end else begin
         addr_err_reg <= addr_err_next;
      end
   end

   assign addr_err = addr_err_reg;

endmodule
